alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial ALU sequencer for the low-area MIPS datapath variant. Accepts two WIDTH-bit operands and a 3-bit ALU op, then drives one existing 1-bit alu slice LSB-first for WIDTH cycles. It holds the carry between bits and shifts the slice's result bit into a result register. It handles slt with a fix-up cycle and reports zero/overflow flags to the branch/control logic.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  000 AND, 001 OR, 010 ADD, 011 XOR, 101 NOR, 110 SUB, 111 SLT
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high from the cycle after accepted start through the last RUN/SLT_FIX cycle
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  final result, held until next accepted start
zero  output  1  result == 0
overflow  output  1  signed overflow for ADD/SUB/SLT, 0 for logic ops

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, busy=0, done=0, result=0, zero=1, overflow=0, bit counter=0, carry=0. Reset applies mid-operation: the operation is aborted silently and no done pulse is produced.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE: on start=1, capture a, b, op into shift registers; set carry = 1 for SUB/SLT, else 0; count=0; go to RUN.
- RUN, one bit per cycle:
  - Drive the slice with a_sh[0] and b_sh[0].
  - For SUB, present b pre-inverted, because the slice inverts b only when op[0]=1. For SLT, present b raw; the slice inverts it.
  - Drive adder_cin=carry and slt_in=0.
  - Register carry<=adder_cout. Shift the result bit into the MSB of the result shift register, then shift right.
  - On count==WIDTH-1, latch overflow = carry_in_msb XOR adder_cout (only for ADD/SUB/SLT), latch less = adder_s XOR overflow, then go to SLT_FIX if op==SLT, else DONE.
  - count increments and wraps to 0 on leaving RUN.
- SLT_FIX: result <= {WIDTH-1 zeros, less}; go to DONE.
- DONE: done=1 for exactly this cycle; result and zero valid; return to IDLE.
- Latency from accepted start to done:
  - WIDTH+1 cycles for non-SLT ops (32 RUN + DONE).
  - WIDTH+2 cycles for SLT.
- start while not IDLE: ignored; no queuing.
- start in the DONE cycle: ignored. The earliest next accept is the following IDLE cycle.
- Carry out of the MSB is discarded. Arithmetic wraps modulo 2^WIDTH.
- Undefined op codes (100): treated as AND, with overflow=0.

Optional Feature:
ALU_SERIAL_FAST_LOGIC_EN
- Defined: AND/OR/XOR/NOR bypass RUN. They are computed WIDTH-wide in parallel in the accept cycle, and the state goes directly to DONE, giving a latency of 1 cycle. overflow=0, busy stays 0, and the slice is idle for these ops.
- Undefined: all ops are serial as above.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_t (3-bit enum with the codes above)
  - typedef seq_state_t (IDLE, RUN, SLT_FIX, DONE)
  - constants OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SUB, OP_SLT
- Single sub-module: the existing 1-bit alu slice, instantiated once. No other hierarchy.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, zero=0, done exactly 33 cycles after start.
- SUB: a=5, b=5 -> result=0, zero=1, overflow=0; a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- SLT: a=0xFFFFFFFF (-1), b=1 -> result=1, done 34 cycles after start; a=0x80000000, b=0x7FFFFFFF -> result=1 (overflow path); a=3, b=-2 -> result=0.
- Logic ops: a=0xF0F0F0F0, b=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NOR 0x000F000F. Check latency 33 without the macro and 1 with ALU_SERIAL_FAST_LOGIC_EN.
- Handshake: pulse start again at cycles 5 and 33 of an ADD -> both ignored, result unchanged. start held high continuously -> back-to-back ops, each with a single-cycle done.
- Reset mid-op: rst_n=0 at RUN count=10 -> next cycle IDLE, result=0, zero=1, no done pulse. A new op then completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, sequencer states and a small helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SLT_FIX,
    DONE
  } seq_state_t;

  // True for ops that go through the adder and can report signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_seq_slice.sv
// One-bit ALU slice. The adder inverts b when op[0] is set, so a sequencer
// wanting b inverted for an op with op[0]=0 must present b already inverted.
// The SLT output is just slt_in passed through; the caller supplies it.
module alu_serial_seq_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       slt_in,
  input  logic [2:0] op,
  output logic       result,
  output logic       adder_s,
  output logic       adder_cout
);

  logic b_add;

  assign b_add      = op[0] ? ~b : b;
  assign adder_s    = a ^ b_add ^ cin;
  assign adder_cout = (a & b_add) | (a & cin) | (b_add & cin);

  // Select the slice output bit for the requested op; unknown codes act as AND.
  always_comb begin
    result = a & b;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = adder_s;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SUB:  result = adder_s;
      OP_SLT:  result = slt_in;
      default: result = a & b;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks one 1-bit slice LSB-first over WIDTH
// cycles, keeping the carry between bits and shifting each result bit into
// the result register from the top. SLT takes one extra fix-up cycle that
// replaces the result with the computed less-than bit.
// Optional build macro ALU_SERIAL_FAST_LOGIC_EN: AND/OR/XOR/NOR (and the
// undefined code treated as AND) are computed full-width in the accept cycle
// and go straight to DONE without touching the slice.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             less_q;

  logic slice_b;
  logic slice_result;
  logic slice_sum;
  logic slice_cout;
  logic ovf_now;

  // SUB has op[0]=0, so the slice will not invert b for it; do it here.
  assign slice_b = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];

  // Overflow as seen on the MSB cycle: carry into the MSB versus carry out.
  assign ovf_now = is_arith(op_q) ? (carry ^ slice_cout) : 1'b0;

  assign zero = (result == '0);

  alu_serial_seq_slice u_slice (
    .a          (a_sh[0]),
    .b          (slice_b),
    .cin        (carry),
    .slt_in     (1'b0),
    .op         (op_q),
    .result     (slice_result),
    .adder_s    (slice_sum),
    .adder_cout (slice_cout)
  );

`ifdef ALU_SERIAL_FAST_LOGIC_EN
  // Full-width version of the slice's logic functions.
  function automatic logic [WIDTH-1:0] logic_word(input logic [2:0] f_op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    case (f_op)
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NOR:  return ~(x | y);
      default: return x & y;
    endcase
  endfunction
`endif

  // Sequencer FSM: accept, serial run, optional SLT fix-up, one-cycle done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      count    <= '0;
      carry    <= 1'b0;
      less_q   <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= OP_AND;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            op_q     <= op;
            carry    <= (op == OP_SUB) || (op == OP_SLT);
            count    <= '0;
            overflow <= 1'b0;
`ifdef ALU_SERIAL_FAST_LOGIC_EN
            if (!is_arith(op)) begin
              result <= logic_word(op, a, b);
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
`else
            busy  <= 1'b1;
            state <= RUN;
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= slice_cout;
          result <= {slice_result, result[WIDTH-1:1]};
          if (count == LAST_BIT) begin
            count    <= '0;
            overflow <= ovf_now;
            less_q   <= slice_sum ^ ovf_now;
            if (op_q == OP_SLT) begin
              state <= SLT_FIX;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        SLT_FIX: begin
          result <= {{(WIDTH-1){1'b0}}, less_q};
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=32). Expected results come
// from a behavioural model, are queued when an op is driven and popped when
// the design raises done. Honours ALU_SERIAL_FAST_LOGIC_EN for latencies.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_SERIAL_FAST_LOGIC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    int           latency;
    logic         busy;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [2:0] m_op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] d;
    e.ovf = 1'b0;
    e.latency = 33;
    e.busy = 1'b1;
    case (m_op)
      OP_OR:  e.result = x | y;
      OP_XOR: e.result = x ^ y;
      OP_NOR: e.result = ~(x | y);
      OP_ADD: begin
        e.result = x + y;
        e.ovf = (x[W-1] == y[W-1]) && (e.result[W-1] != x[W-1]);
      end
      OP_SUB: begin
        e.result = x - y;
        e.ovf = (x[W-1] != y[W-1]) && (e.result[W-1] != x[W-1]);
      end
      OP_SLT: begin
        d = x - y;
        e.ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
        e.result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        e.latency = 34;
      end
      default: e.result = x & y;
    endcase
    if (FAST && !((m_op == OP_ADD) || (m_op == OP_SUB) || (m_op == OP_SLT))) begin
      e.latency = 1;
      e.busy = 1'b0;
    end
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic compareVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single accepted edge, queue its expectation.
  task automatic applyStimulus(input logic [2:0] s_op, input logic [W-1:0] x, input logic [W-1:0] y);
    sb.push_back(model(s_op, x, y));
    start = 1'b1;
    op = s_op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (the accept edge is 1) until done appears, bounded.
  task automatic waitDone(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Pop the oldest expectation and compare outputs in the done cycle.
  task automatic checkOutput(input string tag, input int lat);
    exp_t e;
    compareVal({tag, " done"}, {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s scoreboard: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      compareVal({tag, " result"}, result, e.result);
      compareVal({tag, " zero"}, {31'd0, zero}, {31'd0, e.zero});
      compareVal({tag, " overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
      compareVal({tag, " latency"}, lat, e.latency);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] s_op, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    exp_t e;
    e = model(s_op, x, y);
    applyStimulus(s_op, x, y);
    compareVal({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
    waitDone(lat);
    checkOutput(tag, lat);
    @(posedge clk);
    #1;
    compareVal({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [2:0] lops [5];
    string      lnames [5];
    int lat;
    int cnt;
    int accept_edge;
    logic prev_done;
    exp_t drop;

    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 3'b000;
    a = '0;
    b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compareVal("reset busy", {31'd0, busy}, 32'd0);
    compareVal("reset done", {31'd0, done}, 32'd0);
    compareVal("reset result", result, 32'd0);
    compareVal("reset zero", {31'd0, zero}, 32'd1);
    compareVal("reset overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic and SLT directed cases
    runOp("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    runOp("sub zero", OP_SUB, 32'h0000_0005, 32'h0000_0005);
    runOp("sub ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001);
    runOp("slt neg", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("slt ovf", OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
    runOp("slt pos", OP_SLT, 32'h0000_0003, 32'hFFFF_FFFE);
    runOp("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002);

    // Logic ops plus the undefined code
    lops[0] = OP_AND; lnames[0] = "and";
    lops[1] = OP_OR;  lnames[1] = "or";
    lops[2] = OP_XOR; lnames[2] = "xor";
    lops[3] = OP_NOR; lnames[3] = "nor";
    lops[4] = 3'b100; lnames[4] = "op100";
    for (int i = 0; i < 5; i++) begin
      runOp(lnames[i], lops[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
    end

    // Extra start pulses in RUN (cycle 5) and in DONE (cycle 33) are ignored
    applyStimulus(OP_ADD, 32'h0000_1234, 32'h0000_4321);
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 5) begin
        start = 1'b1;
        op = OP_SUB;
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0007;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    checkOutput("hs", lat);
    start = 1'b1;
    op = OP_SUB;
    @(posedge clk);
    #1;
    start = 1'b0;
    compareVal("hs done pulse", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    compareVal("hs no accept", {31'd0, busy}, 32'd0);
    compareVal("hs result held", result, 32'h0000_5555);

    // Start held high: back-to-back ADDs, each with a single-cycle done
    op = OP_ADD;
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    start = 1'b1;
    repeat (3) sb.push_back(model(OP_ADD, 32'h1111_1111, 32'h2222_2222));
    cnt = 0;
    prev_done = 1'b0;
    accept_edge = 1;
    for (int e = 1; e <= 101; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        compareVal("b2b single done", {31'd0, prev_done}, 32'd0);
        checkOutput("b2b", e - accept_edge + 1);
        accept_edge = e + 2;
      end
      prev_done = done;
    end
    start = 1'b0;
    compareVal("b2b done count", cnt, 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Reset at RUN count 10 aborts silently
    applyStimulus(OP_ADD, 32'h0F0F_0F0F, 32'h0101_0101);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drop = sb.pop_back();
    compareVal("rst busy", {31'd0, busy}, 32'd0);
    compareVal("rst done", {31'd0, done}, 32'd0);
    compareVal("rst result", result, 32'd0);
    compareVal("rst zero", {31'd0, zero}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    compareVal("rst no done", cnt, 32'd0);
    runOp("post rst", OP_SUB, 32'h0000_0010, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
